instr_fetch: RTL and testbench

- Fetch stage directly upstream of the control decoder: owns the program counter, drives the synchronous instruction ROM, and presents one instruction per cycle with its 3-bit opcode.
- Resolves taken branches from the execute stage by redirecting the PC and squashing the in-flight fetch.
- Runs from a Start pulse until a reserved halt word, then asserts Done.

---
 rtl/instr_fetch.sv | 95 +++++++++
 tb/tb_instr_fetch.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Fetch stage: owns the program counter, drives the synchronous instruction ROM,
// and presents one instruction per cycle. Handles branch redirect/squash and halt.
module instr_fetch #(
  parameter int unsigned            PC_WIDTH    = 10,
  parameter int unsigned            INSTR_WIDTH = 9,
  parameter int unsigned            OP_WIDTH    = 3,
  parameter int unsigned            START_ADDR  = 0,
  parameter logic [INSTR_WIDTH-1:0] HALT_WORD   = 9'h1FF
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic                   Start,
  input  logic                   Stall,
  input  logic                   Branch,
  input  logic                   Taken,
  input  logic [PC_WIDTH-1:0]    Target,
  output logic [PC_WIDTH-1:0]    imem_addr,
  output logic                   imem_en,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic [INSTR_WIDTH-1:0] Instr,
  output logic [OP_WIDTH-1:0]    Opcode,
  output logic                   Valid,
  output logic [PC_WIDTH-1:0]    PC,
  output logic                   Done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t              state;
  logic [PC_WIDTH-1:0] fetch_pc;
  logic [PC_WIDTH-1:0] pc_q;
  logic                v_q;
  logic                squash;
  logic                done_q;
  logic                is_halt;
  logic                live;

  // The ROM output register is the instruction register; PC tracks the address
  // that was latched into it, so Instr always belongs to PC.
  assign is_halt   = (imem_rdata == HALT_WORD);
  assign live      = v_q & ~squash;
  assign Valid     = live & ~is_halt;
  assign Instr     = imem_rdata;
  assign Opcode    = imem_rdata[INSTR_WIDTH-1 -: OP_WIDTH];
  assign PC        = pc_q;
  assign Done      = done_q;
  assign imem_addr = fetch_pc;
  assign imem_en   = (state == S_RUN) & ~Stall;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= S_IDLE;
      fetch_pc <= '0;
      pc_q     <= '0;
      v_q      <= 1'b0;
      squash   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (Start) begin
            state    <= S_RUN;
            done_q   <= 1'b0;
            fetch_pc <= PC_WIDTH'(START_ADDR);
            v_q      <= 1'b0;
            squash   <= 1'b0;
          end
        end
        S_RUN: begin
          if (!Stall) begin
            if (live & is_halt) begin
              state  <= S_DONE;
              done_q <= 1'b1;
              v_q    <= 1'b0;
              squash <= 1'b0;
            end else begin
              pc_q <= fetch_pc;
              v_q  <= 1'b1;
              // A taken branch kills the word already being fetched behind it.
              if (Valid & Branch & Taken) begin
                fetch_pc <= Target;
                squash   <= 1'b1;
              end else begin
                fetch_pc <= fetch_pc + 1'b1;
                squash   <= 1'b0;
              end
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized and directed bench for instr_fetch against an address-level
// reference model of the fetch stream (next-fetch address, presented PC, liveness).
module tb_instr_fetch;
  localparam int unsigned PW = 10;
  localparam int unsigned IW = 9;
  localparam int unsigned OW = 3;
  localparam logic [IW-1:0] HALT = 9'h1FF;

  logic          Clk = 1'b0;
  logic          Reset_n = 1'b0;
  logic          Start = 1'b0, Stall = 1'b0, Branch = 1'b0, Taken = 1'b0;
  logic [PW-1:0] Target = '0;
  logic [PW-1:0] imem_addr, PC;
  logic          imem_en, Valid, Done;
  logic [IW-1:0] imem_rdata = '0, Instr;
  logic [OW-1:0] Opcode;

  logic          start2 = 1'b0;
  logic [PW-1:0] imem_addr2, pc2;
  logic          imem_en2, valid2, done2;
  logic [IW-1:0] imem_rdata2 = '0, instr2;
  logic [OW-1:0] opcode2;

  logic [IW-1:0] rom [1024];

  int            n_checks = 0;
  int            n_errors = 0;

  // Reference model: 0 idle, 1 run, 2 done
  int            m_state;
  logic [PW-1:0] m_pc, m_fetch;
  bit            m_live;

  always #5 Clk = ~Clk;

  always @(posedge Clk) if (imem_en)  imem_rdata  <= rom[imem_addr];
  always @(posedge Clk) if (imem_en2) imem_rdata2 <= rom[imem_addr2];

  instr_fetch dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Stall(Stall), .Branch(Branch),
    .Taken(Taken), .Target(Target), .imem_addr(imem_addr), .imem_en(imem_en),
    .imem_rdata(imem_rdata), .Instr(Instr), .Opcode(Opcode), .Valid(Valid),
    .PC(PC), .Done(Done)
  );

  instr_fetch #(.START_ADDR(1022)) dut2 (
    .Clk(Clk), .Reset_n(Reset_n), .Start(start2), .Stall(1'b0), .Branch(1'b0),
    .Taken(1'b0), .Target('0), .imem_addr(imem_addr2), .imem_en(imem_en2),
    .imem_rdata(imem_rdata2), .Instr(instr2), .Opcode(opcode2), .Valid(valid2),
    .PC(pc2), .Done(done2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit exp_valid();
    return (m_state == 1) && m_live && (rom[m_pc] != HALT);
  endfunction

  task automatic check_outputs();
    check("valid", Valid, exp_valid());
    check("done", Done, m_state == 2);
    check("imem_en", imem_en, (m_state == 1) && !Stall);
    if (m_state == 1) check("imem_addr", imem_addr, m_fetch);
    if (exp_valid()) begin
      check("pc", PC, m_pc);
      check("instr", Instr, rom[m_pc]);
      check("opcode", Opcode, rom[m_pc][IW-1 -: OW]);
    end
  endtask

  task automatic model_step();
    if (m_state != 1) begin
      if (Start) begin
        m_state = 1;
        m_fetch = PW'(0);
        m_live  = 0;
      end
    end else if (!Stall) begin
      if (m_live && rom[m_pc] == HALT) begin
        m_state = 2;
        m_live  = 0;
      end else if (m_live && Branch && Taken) begin
        m_pc    = m_fetch;
        m_fetch = Target;
        m_live  = 0;
      end else begin
        m_pc    = m_fetch;
        m_fetch = m_fetch + 1'b1;
        m_live  = 1;
      end
    end
  endtask

  task automatic step(input bit st, input bit sl, input bit br, input bit tk,
                      input logic [PW-1:0] tg);
    Start = st; Stall = sl; Branch = br; Taken = tk; Target = tg;
    #1;
    check_outputs();
    @(posedge Clk);
    model_step();
    #1;
  endtask

  task automatic model_reset();
    m_state = 0; m_pc = '0; m_fetch = '0; m_live = 0;
  endtask

  task automatic do_reset();
    Reset_n = 1'b0; Start = 0; Stall = 0; Branch = 0; Taken = 0; start2 = 0;
    model_reset();
    repeat (2) @(posedge Clk);
    #1 Reset_n = 1'b1;
    check("rst_valid", Valid, 0);
    check("rst_done", Done, 0);
    check("rst_pc", PC, 0);
    check("rst_imem_en", imem_en, 0);
  endtask

  task automatic run_until_pc(input logic [PW-1:0] want);
    bit found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (exp_valid() && m_pc == want) found = 1;
      else step(0, 0, 0, 0, '0);
    end
    check("reach_pc_timeout", found, 1);
  endtask

  task automatic fill_rom_linear();
    for (int i = 0; i < 1024; i++) rom[i] = IW'(i % 500);
  endtask

  initial begin
    logic [PW-1:0] seq2 [4];
    bit            halted;
    seq2[0] = 10'd1022; seq2[1] = 10'd1023; seq2[2] = 10'd0; seq2[3] = 10'd1;

    // Short program ending in the halt word
    fill_rom_linear();
    rom[0] = 9'b011_000001;
    rom[1] = 9'b010_000010;
    rom[2] = HALT;
    do_reset();
    step(1, 0, 0, 0, '0);
    step(0, 0, 0, 0, '0);
    check("t1_c2_valid", Valid, 1);
    check("t1_c2_pc", PC, 0);
    check("t1_c2_op", Opcode, 3'b011);
    step(0, 0, 0, 0, '0);
    check("t1_c3_valid", Valid, 1);
    check("t1_c3_pc", PC, 1);
    check("t1_c3_op", Opcode, 3'b010);
    step(0, 0, 0, 0, '0);
    check("t1_c4_halt_not_valid", Valid, 0);
    step(0, 0, 0, 0, '0);
    check("t1_c5_done", Done, 1);
    step(0, 0, 0, 0, '0);
    fill_rom_linear();

    // Taken branch: one bubble; not-taken branch: none
    step(1, 0, 0, 0, '0);
    run_until_pc(4);
    step(0, 0, 1, 1, 10'd20);
    check("t2_squash_valid", Valid, 0);
    check("t2_squash_pc", PC, 5);
    step(0, 0, 0, 0, '0);
    check("t2_target_valid", Valid, 1);
    check("t2_target_pc", PC, 20);
    run_until_pc(24);
    step(0, 0, 1, 0, 10'd99);
    check("t2_nt_valid", Valid, 1);
    check("t2_nt_pc", PC, 25);

    // START_ADDR near the top wraps the PC (second instance, main one idle)
    do_reset();
    start2 = 1'b1;
    @(posedge Clk); #1 start2 = 1'b0;
    @(posedge Clk); #1;
    for (int i = 0; i < 4; i++) begin
      check("t4_wrap_valid", valid2, 1);
      check("t4_wrap_pc", pc2, seq2[i]);
      @(posedge Clk); #1;
    end

    // Stall holds everything; a branch under stall redirects only on release
    step(1, 0, 0, 0, '0);
    run_until_pc(7);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 0, '0);
      check("t3_stall_pc", PC, 7);
      check("t3_stall_valid", Valid, 1);
    end
    step(0, 0, 0, 0, '0);
    check("t3_release_pc", PC, 8);
    run_until_pc(12);
    step(0, 1, 1, 1, 10'd40);
    step(0, 1, 1, 1, 10'd40);
    check("t3_brstall_pc", PC, 12);
    step(0, 0, 1, 1, 10'd40);
    check("t3_brrel_squash", Valid, 0);
    step(0, 0, 0, 0, '0);
    check("t3_brrel_pc", PC, 40);

    // Asynchronous reset between edges
    run_until_pc(45);
    #2 Reset_n = 1'b0;
    #1;
    model_reset();
    check("t5_valid", Valid, 0);
    check("t5_done", Done, 0);
    check("t5_imem_en", imem_en, 0);
    check("t5_pc", PC, 0);
    check("t5_imem_addr", imem_addr, 0);
    @(posedge Clk); #1 Reset_n = 1'b1;
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, '0);

    // Halt word in the squashed slot is ignored; restart from DONE; Start in RUN ignored
    rom[31] = HALT;
    rom[55] = HALT;
    step(1, 0, 0, 0, '0);
    run_until_pc(30);
    step(0, 0, 1, 1, 10'd50);
    check("t6_squash_pc", PC, 31);
    check("t6_squash_valid", Valid, 0);
    step(0, 0, 0, 0, '0);
    check("t6_target_pc", PC, 50);
    check("t6_target_valid", Valid, 1);
    check("t6_no_done", Done, 0);
    halted = 0;
    for (int i = 0; i < 20 && !halted; i++) begin
      if (m_state == 2) halted = 1;
      else step(0, 0, 0, 0, '0);
    end
    check("t6_halt_timeout", halted, 1);
    check("t6_done", Done, 1);
    step(1, 0, 0, 0, '0);
    step(0, 0, 0, 0, '0);
    check("t6_restart_pc", PC, 0);
    check("t6_restart_valid", Valid, 1);
    check("t6_restart_done", Done, 0);
    step(1, 0, 0, 0, '0);
    check("t6_start_in_run_pc", PC, 1);
    fill_rom_linear();

    // Randomized run against the model
    do_reset();
    for (int i = 0; i < 1024; i++)
      rom[i] = ($urandom_range(0, 99) < 3) ? HALT : IW'($urandom_range(0, 510));
    for (int i = 0; i < 1500; i++) begin
      bit st;
      st = (m_state != 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
      step(st, $urandom_range(0, 3) == 0, 1'($urandom), 1'($urandom),
           PW'($urandom_range(0, 1023)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
